// File: rtl/alu_writeback.sv
// alu_writeback: holds one ALU result, commits it conditionally to a 16x32 register file and NZCV, with forwarded read ports
module alu_writeback #(
    parameter int NREG  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inf,
    input  logic [31:0]      alu_r,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             wb_stall,
    input  logic [3:0]       ra_addr,
    input  logic [3:0]       rb_addr,
    output logic [31:0]      ra_data,
    output logic [31:0]      rb_data,
    output logic [3:0]       flags,
    output logic             wb_we,
    output logic [3:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] skip_cnt
);
    logic             hv;
    logic [12:0]      hi;
    logic [31:0]      hr;
    logic [3:0]       hf;
    logic [31:0]      rf [NREG];
    logic [3:0]       cond, op, rd;
    logic             s, base, pass, commit, fupd, unused_inf;
    assign cond = hi[12:9];
    assign op   = hi[8:5];
    assign s    = hi[4];
    assign rd   = hi[3:0];
    // odd condition codes are the inverse of the even code below them
    always_comb begin
        case (cond[3:1])
            3'd0: base = flags[2];
            3'd1: base = flags[1];
            3'd2: base = flags[3];
            3'd3: base = flags[0];
            3'd4: base = flags[1] & ~flags[2];
            3'd5: base = flags[3] == flags[0];
            3'd6: base = ~flags[2] & (flags[3] == flags[0]);
            default: base = 1'b1;
        endcase
        pass = base ^ cond[0];
    end
    assign commit     = rst_n & hv & ~wb_stall;
    assign in_ready   = ~hv | ~wb_stall;
    assign wb_we      = commit & pass & ~op[3];
    assign fupd       = commit & pass & ((op == 4'b1000) | (s & ~op[3]));
    assign wb_rd      = wb_we ? rd : 4'd0;
    assign wb_data    = wb_we ? hr : 32'd0;
    assign ra_data    = (wb_we && ra_addr == wb_rd) ? wb_data : rf[ra_addr];
    assign rb_data    = (wb_we && rb_addr == wb_rd) ? wb_data : rf[rb_addr];
    assign unused_inf = &{1'b0, inf[18:0]};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hv         <= 1'b0;
            hi         <= '0;
            hr         <= '0;
            hf         <= '0;
            flags      <= '0;
            retire_cnt <= '0;
            skip_cnt   <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (in_valid && in_ready) {hi, hr, hf} <= {inf[31:19], alu_r, alu_n, alu_z, alu_c, alu_v};
            hv <= (in_valid & in_ready) | (hv & wb_stall);
            if (wb_we) rf[rd] <= hr;
            if (fupd) flags <= hf;
            if (commit && pass && !(&retire_cnt)) retire_cnt <= retire_cnt + 1'b1;
            if (commit && !pass && !(&skip_cnt)) skip_cnt <= skip_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenario tasks with hand-computed expectations for alu_writeback
module tb_alu_writeback;
    logic        clk = 0, rst_n = 0, in_valid = 0, wb_stall = 0;
    logic [31:0] inf = 0, alu_r = 0;
    logic        alu_n = 0, alu_z = 0, alu_c = 0, alu_v = 0;
    logic [3:0]  ra_addr = 0, rb_addr = 0;
    logic        in_ready, wb_we;
    logic [31:0] ra_data, rb_data, wb_data;
    logic [3:0]  flags, wb_rd;
    logic [15:0] retire_cnt, skip_cnt;
    int checks = 0, errors = 0;

    alu_writeback dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inf(inf),
        .alu_r(alu_r), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .wb_stall(wb_stall), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data),
        .rb_data(rb_data), .flags(flags), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_cnt(retire_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic put(input logic v, input logic [31:0] i, input logic [31:0] r, input logic [3:0] f);
        in_valid = v;
        inf = i;
        alu_r = r;
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    function automatic logic [31:0] ins(input logic [3:0] c, input logic [3:0] o, input logic s, input logic [3:0] rd);
        return {c, o, s, rd, 19'd0};
    endfunction

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", flags); end
        checks++; if ({wb_we, wb_rd, wb_data} !== 37'd0) begin errors++; $display("FAIL reset_wb: got %b/%h/%h want 0/0/0", wb_we, wb_rd, wb_data); end
        checks++; if ({retire_cnt, skip_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", retire_cnt, skip_cnt); end
    endtask

    task automatic test_basic;
        @(posedge clk); #1 put(1, 32'hE0080000, 32'd5, 4'h0); ra_addr = 1;
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 4'd1, 32'd5}) begin errors++; $display("FAIL basic_wb: got %b/%h/%h want 1/1/5", wb_we, wb_rd, wb_data); end
        checks++; if (ra_data !== 32'd5) begin errors++; $display("FAIL basic_bypass: got %h want 5", ra_data); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL basic_we_off: got %b want 0", wb_we); end
        checks++; if (retire_cnt !== 16'd1 || flags !== 4'h0) begin errors++; $display("FAIL basic_state: got %0d/%h want 1/0", retire_cnt, flags); end
        checks++; if (ra_data !== 32'd5) begin errors++; $display("FAIL basic_r1: got %h want 5", ra_data); end
    endtask

    task automatic test_cmp;
        @(posedge clk); #1 put(1, 32'hE8800000, 32'h0, 4'b0100);
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL cmp_we: got %b want 0", wb_we); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL cmp_flags_late: got %h want 0", flags); end
        @(posedge clk); #1 put(1, ins(4'h0, 4'h0, 0, 4'd2), 32'd7, 4'h0); ra_addr = 2;
        @(negedge clk);
        checks++; if (flags !== 4'b0100 || retire_cnt !== 16'd2) begin errors++; $display("FAIL cmp_flags: got %h/%0d want 4/2", flags, retire_cnt); end
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 4'd2, 32'd7}) begin errors++; $display("FAIL eq_wb: got %b/%h/%h want 1/2/7", wb_we, wb_rd, wb_data); end
        @(posedge clk); #1 put(1, ins(4'h1, 4'h0, 0, 4'd5), 32'd9, 4'h0); ra_addr = 5;
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL ne_we: got %b want 0", wb_we); end
        @(posedge clk); #1 put(1, ins(4'hE, 4'h9, 1, 4'd6), 32'd3, 4'b1111);
        @(negedge clk);
        checks++; if (skip_cnt !== 16'd1 || retire_cnt !== 16'd3 || ra_data !== 32'd0) begin errors++; $display("FAIL ne_skip: got %0d/%0d/%h want 1/3/0", skip_cnt, retire_cnt, ra_data); end
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL op9_we: got %b want 0", wb_we); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (flags !== 4'b0100 || retire_cnt !== 16'd4) begin errors++; $display("FAIL op9_state: got %h/%0d want 4/4", flags, retire_cnt); end
        ra_addr = 2;
        @(negedge clk);
        checks++; if (ra_data !== 32'd7) begin errors++; $display("FAIL eq_r2: got %h want 7", ra_data); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 put(1, ins(4'hE, 4'h1, 0, 4'(6 + i)), 32'(100 + i), 4'h0);
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            if (i > 0) begin
                checks++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 4'(5 + i), 32'(99 + i)}) begin errors++; $display("FAIL b2b_wb%0d: got %b/%h/%h want 1/%h/%h", i, wb_we, wb_rd, wb_data, 5 + i, 99 + i); end
            end
        end
        @(posedge clk); #1 put(0, 0, 0, 0); rb_addr = 7;
        @(negedge clk);
        checks++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 4'd9, 32'd103}) begin errors++; $display("FAIL b2b_wb3: got %b/%h/%h want 1/9/67", wb_we, wb_rd, wb_data); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (retire_cnt !== 16'd8 || rb_data !== 32'd101) begin errors++; $display("FAIL b2b_done: got %0d/%h want 8/65", retire_cnt, rb_data); end
    endtask

    task automatic test_stall;
        @(posedge clk); #1 put(1, ins(4'hE, 4'h0, 0, 4'd10), 32'hA, 4'h0);
        @(posedge clk); #1 put(1, ins(4'hE, 4'h0, 0, 4'd11), 32'hB, 4'h0); wb_stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL stall%0d: got ready=%b we=%b want 0/0", i, in_ready, wb_we); end
            @(posedge clk); #1;
        end
        wb_stall = 0;
        @(negedge clk);
        checks++; if (retire_cnt !== 16'd8) begin errors++; $display("FAIL stall_cnt: got %0d want 8", retire_cnt); end
        checks++; if ({in_ready, wb_we, wb_rd, wb_data} !== {2'b11, 4'd10, 32'hA}) begin errors++; $display("FAIL stall_release: got %b/%b/%h/%h want 1/1/a/a", in_ready, wb_we, wb_rd, wb_data); end
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 4'd11, 32'hB}) begin errors++; $display("FAIL stall_next: got %b/%h/%h want 1/b/b", wb_we, wb_rd, wb_data); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (retire_cnt !== 16'd10) begin errors++; $display("FAIL stall_done: got %0d want 10", retire_cnt); end
    endtask

    task automatic test_bypass;
        @(posedge clk); #1 put(1, ins(4'hE, 4'h2, 0, 4'd3), 32'hDEADBEEF, 4'h0); ra_addr = 3; rb_addr = 10;
        @(posedge clk); #1 put(0, 0, 0, 0);
        @(negedge clk);
        checks++; if (ra_data !== 32'hDEADBEEF || rb_data !== 32'hA) begin errors++; $display("FAIL bypass: got %h/%h want deadbeef/a", ra_data, rb_data); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wb_we !== 1'b0 || ra_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rf: got %b/%h want 0/deadbeef", wb_we, ra_data); end
    endtask

    task automatic test_reset_inflight;
        @(posedge clk); #1 put(1, ins(4'hE, 4'h0, 1, 4'd4), 32'h1234, 4'b1111); ra_addr = 4; rb_addr = 3;
        @(posedge clk); #1 put(0, 0, 0, 0); rst_n = 0;
        @(negedge clk);
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", wb_we); end
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        checks++; if (ra_data !== 32'd0 || rb_data !== 32'd0) begin errors++; $display("FAIL rst_rf: got %h/%h want 0/0", ra_data, rb_data); end
        checks++; if (flags !== 4'h0 || retire_cnt !== 16'd0 || skip_cnt !== 16'd0) begin errors++; $display("FAIL rst_state: got %h/%0d/%0d want 0/0/0", flags, retire_cnt, skip_cnt); end
        checks++; if (in_ready !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b/%b want 1/0", in_ready, wb_we); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ra_data !== 32'd0 || retire_cnt !== 16'd0) begin errors++; $display("FAIL rst_discard: got %h/%0d want 0/0", ra_data, retire_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_cmp;
        test_back_to_back;
        test_stall;
        test_bypass;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
